// File: rtl/c1_sub4b_seq_if.sv
// ----------------------------------------------------------------------------
// c1_sub4b_seq_if
// Bundles the request, operand and result signals of the bit-serial
// ones'-complement subtractor.
//   start      : request to begin a subtraction (master -> slave)
//   x, y       : 4-bit C1 minuend / subtrahend   (master -> slave)
//   z          : 4-bit C1 result x - y, registered (slave -> master)
//   ovf        : C1 overflow flag of the last result (slave -> master)
//   busy       : operation in progress           (slave -> master)
//   done       : one-cycle pulse, z/ovf valid    (slave -> master)
// ----------------------------------------------------------------------------
interface c1_sub4b_seq_if;
   logic       start;
   logic [3:0] x;
   logic [3:0] y;
   logic [3:0] z;
   logic       ovf;
   logic       busy;
   logic       done;

   modport master (
      output start, x, y,
      input  z, ovf, busy, done
   );

   modport slave (
      input  start, x, y,
      output z, ovf, busy, done
   );
endinterface

// File: rtl/c1_sub4b_seq.sv
// ----------------------------------------------------------------------------
// c1_sub4b_seq
// Bit-serial ones'-complement subtractor: z = x + ~y with end-around carry.
// A start in IDLE or DONE latches A = x and B = ~y, then four ADD cycles
// run one full-adder bit per cycle LSB first, one EAC cycle folds the final
// carry back in and updates z/ovf, and DONE pulses done for one cycle.
// Ports:
//   clk   : single clock, rising edge
//   rst_b : asynchronous active-low reset
//   bus   : slave side of c1_sub4b_seq_if (start, x, y, z, ovf, busy, done)
// ----------------------------------------------------------------------------
module c1_sub4b_seq (
   input  logic          clk,
   input  logic          rst_b,
   c1_sub4b_seq_if.slave bus
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_ADD  = 2'd1;
   localparam logic [1:0] ST_EAC  = 2'd2;
   localparam logic [1:0] ST_DONE = 2'd3;

   logic [1:0] state_q, state_d;
   logic [3:0] a_q, a_d;
   logic [3:0] b_q, b_d;
   logic [3:0] res_q, res_d;
   logic [3:0] z_q, z_d;
   logic [1:0] cnt_q, cnt_d;
   logic       carry_q, carry_d;
   logic       ovf_q, ovf_d;
   logic       busy_q, busy_d;
   logic       done_q, done_d;

   logic [1:0] fa_s;        // {carry_out, sum} of the current bit
   logic [3:0] eac_sum_s;   // result with end-around carry folded in

   // One-bit full adder, returns {carry_out, sum}
   function automatic logic [1:0] full_add(input logic a, input logic b, input logic cin);
      full_add = {(a & b) | (a & cin) | (b & cin), a ^ b ^ cin};
   endfunction

   // Next-state, datapath and output computation
   always_comb begin
      state_d   = state_q;
      a_d       = a_q;
      b_d       = b_q;
      res_d     = res_q;
      z_d       = z_q;
      cnt_d     = cnt_q;
      carry_d   = carry_q;
      ovf_d     = ovf_q;
      busy_d    = 1'b0;
      done_d    = 1'b0;
      fa_s      = full_add(a_q[cnt_q], b_q[cnt_q], carry_q);
      eac_sum_s = res_q + {3'b000, carry_q};

      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (bus.start) begin
               state_d = ST_ADD;
               a_d     = bus.x;
               b_d     = ~bus.y;
               res_d   = 4'b0000;
               carry_d = 1'b0;
               cnt_d   = 2'd0;
               busy_d  = 1'b1;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_ADD: begin
            // Sum bits enter at the MSB so bit 0 lands at res[0] after 4 shifts
            res_d   = {fa_s[0], res_q[3:1]};
            carry_d = fa_s[1];
            cnt_d   = cnt_q + 2'd1;
            busy_d  = 1'b1;
            if (cnt_q == 2'd3) begin
               state_d = ST_EAC;
            end else begin
               state_d = ST_ADD;
            end
         end
         ST_EAC: begin
            res_d   = eac_sum_s;
            z_d     = eac_sum_s;
            carry_d = 1'b0;
            // Sign rule is applied to the corrected (post end-around) result
            ovf_d   = (a_q[3] == b_q[3]) && (eac_sum_s[3] != a_q[3]);
            done_d  = 1'b1;
            state_d = ST_DONE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and output registers with asynchronous reset
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         state_q <= ST_IDLE;
         a_q     <= 4'b0000;
         b_q     <= 4'b0000;
         res_q   <= 4'b0000;
         z_q     <= 4'b0000;
         cnt_q   <= 2'd0;
         carry_q <= 1'b0;
         ovf_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         res_q   <= res_d;
         z_q     <= z_d;
         cnt_q   <= cnt_d;
         carry_q <= carry_d;
         ovf_q   <= ovf_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign bus.z    = z_q;
   assign bus.ovf  = ovf_q;
   assign bus.busy = busy_q;
   assign bus.done = done_q;

endmodule

// File: tb/tb_c1_sub4b_seq.sv
// ----------------------------------------------------------------------------
// tb_c1_sub4b_seq
// Scoreboard bench for c1_sub4b_seq: expected {ovf, z} is queued whenever a
// start is issued that the block must accept, and popped on every done.
// ----------------------------------------------------------------------------
module tb_c1_sub4b_seq;

   logic clk;
   logic rst_b;
   int   n_total;
   int   n_bad;
   logic [4:0] sb_q[$];
   logic [4:0] exp_v;

   c1_sub4b_seq_if bus_if ();

   c1_sub4b_seq dut (
      .clk   (clk),
      .rst_b (rst_b),
      .bus   (bus_if.slave)
   );

   // Free-running clock, 10 time-unit period
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_total++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Reference C1 subtraction: x + ~y, end-around carry, sign-rule overflow
   function automatic logic [4:0] ref_sub(input logic [3:0] xa, input logic [3:0] ya);
      logic [3:0] bb;
      logic [4:0] s;
      logic [3:0] r;
      bb = ~ya;
      s  = {1'b0, xa} + {1'b0, bb};
      r  = s[3:0] + {3'b000, s[4]};
      return {(xa[3] == bb[3]) && (r[3] != xa[3]), r};
   endfunction

   // Compare every done against the scoreboard
   always @(negedge clk) begin
      if (rst_b && bus_if.done === 1'b1) begin
         chk("sb_nonempty", {7'd0, sb_q.size() != 0}, 8'd1);
         if (sb_q.size() != 0) begin
            exp_v = sb_q.pop_front();
            chk("z",   {4'd0, bus_if.z},   {4'd0, exp_v[3:0]});
            chk("ovf", {7'd0, bus_if.ovf}, {7'd0, exp_v[4]});
         end
      end
   end

   task automatic launch(input logic [3:0] xa, input logic [3:0] ya, input logic [4:0] e);
      bus_if.start = 1'b1;
      bus_if.x     = xa;
      bus_if.y     = ya;
      sb_q.push_back(e);
   endtask

   // Called just after the edge following launch; waits for done (bounded)
   task automatic finish_op(input logic [3:0] xa, input logic [3:0] ya, input bit glitch);
      int lat;
      @(posedge clk); #1;
      bus_if.start = 1'b0;
      lat = 0;
      while (bus_if.done !== 1'b1 && lat < 20) begin
         chk("busy_run", {7'd0, bus_if.busy}, 8'd1);
         if (glitch && lat == 1) begin
            bus_if.start = 1'b1;
            bus_if.x     = ~xa;
            bus_if.y     = ~ya;
         end
         if (glitch && lat == 2) begin
            bus_if.start = 1'b0;
         end
         @(posedge clk); #1;
         lat++;
      end
      chk("latency", 8'(lat), 8'd5);
      chk("busy_done", {7'd0, bus_if.busy}, 8'd0);
   endtask

   task automatic do_op(input logic [3:0] xa, input logic [3:0] ya, input logic [4:0] e, input bit glitch);
      @(posedge clk); #1;
      launch(xa, ya, e);
      finish_op(xa, ya, glitch);
   endtask

   initial begin
      n_total      = 0;
      n_bad        = 0;
      rst_b        = 1'b0;
      bus_if.start = 1'b0;
      bus_if.x     = 4'b0000;
      bus_if.y     = 4'b0000;
      #12;
      chk("rst_z",    {4'd0, bus_if.z},    8'd0);
      chk("rst_ovf",  {7'd0, bus_if.ovf},  8'd0);
      chk("rst_busy", {7'd0, bus_if.busy}, 8'd0);
      chk("rst_done", {7'd0, bus_if.done}, 8'd0);
      @(posedge clk); #1;
      rst_b = 1'b1;

      // Directed scenarios with hand-derived results
      do_op(4'b0101, 4'b0011, {1'b0, 4'b0010}, 1'b0);
      do_op(4'b0011, 4'b0101, {1'b0, 4'b1101}, 1'b0);
      do_op(4'b0000, 4'b0000, {1'b0, 4'b1111}, 1'b0);
      do_op(4'b0111, 4'b1000, {1'b1, 4'b1110}, 1'b0);
      do_op(4'b1000, 4'b0111, {1'b1, 4'b0001}, 1'b0);
      do_op(4'b1111, 4'b0111, {1'b0, 4'b1000}, 1'b0);

      // Start re-pulsed and operands changed during ADD
      do_op(4'b0110, 4'b0010, {1'b0, 4'b0100}, 1'b1);

      // start held high: done every 6 cycles, busy low only in DONE
      @(posedge clk); #1;
      launch(4'b0001, 4'b0001, {1'b0, 4'b1111});
      for (int op = 0; op < 4; op++) begin
         for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            chk("b2b_busy", {7'd0, bus_if.busy}, {7'd0, c < 5});
            chk("b2b_done", {7'd0, bus_if.done}, {7'd0, c == 5});
         end
         if (op == 0) begin
            launch(4'b0110, 4'b1100, ref_sub(4'b0110, 4'b1100));
         end else if (op == 1) begin
            launch(4'b1010, 4'b0101, ref_sub(4'b1010, 4'b0101));
         end else if (op == 2) begin
            launch(4'b0010, 4'b0100, ref_sub(4'b0010, 4'b0100));
         end else begin
            bus_if.start = 1'b0;
         end
      end

      // Reset during ADD: abort, clear z, no done
      @(posedge clk); #1;
      launch(4'b1010, 4'b0001, ref_sub(4'b1010, 4'b0001));
      @(posedge clk); #1;
      bus_if.start = 1'b0;
      @(posedge clk); #1;
      chk("mid_busy", {7'd0, bus_if.busy}, 8'd1);
      rst_b = 1'b0;
      void'(sb_q.pop_back());
      #1;
      chk("abort_z",    {4'd0, bus_if.z},    8'd0);
      chk("abort_busy", {7'd0, bus_if.busy}, 8'd0);
      chk("abort_done", {7'd0, bus_if.done}, 8'd0);
      repeat (8) @(posedge clk);
      #1;
      chk("abort_z_hold", {4'd0, bus_if.z}, 8'd0);

      // First start after reset release must be taken on the first edge
      rst_b = 1'b1;
      launch(4'b0100, 4'b0001, {1'b0, 4'b0011});
      finish_op(4'b0100, 4'b0001, 1'b0);

      // Exhaustive sweep against the reference model
      for (int i = 0; i < 256; i++) begin
         logic [7:0] iv;
         iv = 8'(i);
         do_op(iv[7:4], iv[3:0], ref_sub(iv[7:4], iv[3:0]), 1'b0);
      end

      repeat (10) @(posedge clk);
      #1;
      chk("sb_empty", 8'(sb_q.size()), 8'd0);
      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule

// File: doc/c1_sub4b_seq.md
C1_SUB4B_SEQ -- requirements
Module: c1_sub4b_seq

Interface
REQ-001 The block SHALL have the port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-002 The block SHALL have the port rst_b, input, 1 bit, asynchronous active-low reset.
REQ-003 The block SHALL have the port start, input, 1 bit, request to begin a subtraction; sampled on a rising clk edge.
REQ-004 The block SHALL have the port x, input, 4 bits, minuend in C1; sampled when start is accepted.
REQ-005 The block SHALL have the port y, input, 4 bits, subtrahend in C1; sampled when start is accepted.
REQ-006 The block SHALL have the port z, output, 4 bits, C1 result x - y; registered.
REQ-007 The block SHALL have the port ovf, output, 1 bit, C1 overflow flag for the last result; registered.
REQ-008 The block SHALL have the port busy, output, 1 bit, high while an operation is in progress.
REQ-009 The block SHALL have the port done, output, 1 bit, one-cycle pulse marking z/ovf valid.

Function
REQ-010 The block SHALL compute z = x + ~y (4-bit) with end-around carry, i.e. C1 subtraction x - y.
REQ-011 The block SHALL implement the FSM states IDLE, ADD, EAC and DONE.
REQ-012 In IDLE or DONE, the block SHALL accept start=1 at a rising edge: latch operand A=x and operand B=~y, clear the carry FF and the bit counter, and go to ADD.
REQ-013 ADD SHALL be bit-serial and LSB first, processing exactly 4 cycles, one full-adder bit per cycle (A[i], B[i], carry) with the sum shifted into the result register and the carry FF updated.
REQ-014 After the 4th ADD cycle the block SHALL go to EAC, where it adds the final carry-out to the 4-bit result modulo 16 in one cycle; no carry-out is kept.
REQ-015 In EAC the block SHALL set ovf=1 when A[3]==B[3] and result[3]!=A[3]; otherwise it SHALL set ovf=0.
REQ-016 After EAC the block SHALL update z and ovf at the same edge it enters DONE.
REQ-017 done SHALL be 1 only in DONE, for exactly one cycle.
REQ-018 From DONE the block SHALL go to IDLE, or to ADD if start=1.
REQ-019 Latency SHALL be: start accepted at edge k; done high in the cycle after edge k+5; z valid from edge k+5.
REQ-020 busy SHALL be 1 in ADD and EAC, and 0 in IDLE and DONE.
REQ-021 start SHALL be ignored while busy=1; the operands in flight SHALL be unaffected by x/y changes.
REQ-022 z and ovf SHALL hold their last value until the next EAC completes; they SHALL not change during ADD.
REQ-023 Negative zero (1111) SHALL be a legal result and SHALL not be normalised to 0000.
REQ-024 The bit counter SHALL be 2 bits and SHALL wrap 3->0 when leaving ADD.

Reset
REQ-025 rst_b=0 SHALL force, immediately and independent of clk, state=IDLE, z=0000, ovf=0, busy=0, done=0, with the carry FF, counter and operand registers cleared.
REQ-026 Reset mid-operation SHALL abort the operation, emit no done pulse, and leave z at 0000.
REQ-027 The first start after rst_b rises SHALL be accepted on the first rising edge with rst_b=1.

Verification
REQ-028 Scenario 1: x=0101, y=0011, start for 1 cycle -> busy for 5 cycles, then done pulse; z=0010, ovf=0.
REQ-029 Scenario 2: x=0011, y=0101 -> z=1101 (-2), ovf=0; x=0000, y=0000 -> z=1111 (-0), ovf=0.
REQ-030 Scenario 3: x=0111, y=1000 (7 - (-7)) -> z=1110, ovf=1; then x=1000, y=0111 -> z=0001, ovf=1.
REQ-031 Scenario 4: start pulsed again and x/y changed during ADD -> result matches the originally latched operands; exactly one done.
REQ-032 Scenario 5: start held high continuously -> back-to-back operations, done every 6 cycles, busy low only in DONE.
REQ-033 Scenario 6: rst_b dropped during ADD -> z=0000, busy=0, no done; then an exhaustive 256-pair sweep SHALL match a reference model of x + ~y with end-around carry for z, plus the sign rule of REQ-015 for ovf.
